// File: rtl/fa_accum_ctrl.sv
// Frame accumulator wrapped around an external combinational adder.
// Samples are summed frame by frame; the total, beat count and wrap flag go out on a valid/ready port.
module fa_accum_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic             wrap;
  logic [CNT_W-1:0] cnt_nx;

  assign add_a  = acc;
  assign add_b  = in_data;
  assign accept = in_valid & in_ready;
  // a modulo sum smaller than the old accumulator means the adder carried out
  assign wrap   = (add_sum < acc);
  assign cnt_nx = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt_nx;
            ovf <= ovf | wrap;
            if (in_last) begin
              res_data  <= add_sum;
              res_count <= cnt_nx;
              res_ovf   <= ovf | wrap;
              res_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_accum_ctrl.sv
// Randomized bench for fa_accum_ctrl; frame totals are predicted from plain integer sums.
module tb_fa_accum_ctrl;
  localparam int W = 16;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] add_a, add_b, add_sum;
  logic [W-1:0] res_data;
  logic [C-1:0] res_count;
  logic         res_ovf, res_valid;
  logic         res_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  // the external adder
  assign add_sum = add_a + add_b;

  fa_accum_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_data(res_data), .res_count(res_count), .res_ovf(res_ovf),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive the frame held in q with random gaps, hold the result for `hold` cycles, then handshake.
  task automatic run_frame(input int gap_pct, input int hold);
    longint       tot = 0;
    int           n = q.size();
    int           i = 0;
    int           guard = 0;
    logic [W-1:0] exp_d;
    logic [C-1:0] exp_c;
    logic         exp_o;
    while (i < n && guard < 50 * n + 50) begin
      @(negedge clk);
      guard++;
      chk("in_ready_open", in_ready, 1);
      chk("add_a_running", add_a, tot[W-1:0]);
      chk("res_valid_open", res_valid, 0);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? q[i] : W'($urandom);
      in_last  = in_valid ? (i == n - 1) : 1'($urandom);
      #1 chk("add_b", add_b, in_data);
      @(posedge clk);
      if (in_valid) begin
        tot += q[i];
        i++;
      end
    end
    if (i < n) chk("frame_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_d = tot[W-1:0];
    exp_c = (n > 255) ? C'(255) : C'(n);
    exp_o = (tot >= 65536);
    for (int h = 0; h <= hold; h++) begin
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, exp_d);
      chk("res_count", res_count, exp_c);
      chk("res_ovf", res_ovf, exp_o);
      chk("in_ready_done", in_ready, 0);
      if (h < hold) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_clear", res_valid, 0);
    chk("in_ready_reopen", in_ready, 1);
    chk("acc_clear", add_a, 0);
    q.delete();
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_add_a", add_a, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_ovf", res_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    q = '{16'd3, 16'd5, 16'd7};            run_frame(0, 0);
    q = '{16'h1234};                       run_frame(0, 0);
    q = '{16'hFFF0, 16'h0020};             run_frame(0, 0);
    q = '{16'd1, 16'd1};                   run_frame(0, 0);
    q = '{16'd1, 16'd2, 16'd3};            run_frame(50, 5);
    for (int k = 0; k < 300; k++) q.push_back(16'd1);
    run_frame(0, 1);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd9; in_last = 1'b0;
    @(negedge clk);
    in_data = 16'd11;
    @(posedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_add_a", add_a, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_res_count", res_count, 0);
    chk("arst_res_ovf", res_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q = '{16'd4, 16'd4};                   run_frame(0, 0);

    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++)
        q.push_back(($urandom_range(1) == 1) ? W'($urandom) : W'($urandom_range(0, 255)));
      run_frame(30, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fa_accum_ctrl.md
Name: fa_accum_ctrl

Overview:
- Sequencing and accumulation stage wrapped around the 16-bit combinational adder (a + b -> out).
- Accepts a stream of unsigned 16-bit samples grouped into frames. Each accepted sample is added to the running sum by driving the adder operand ports; the adder's sum is registered back.
- At frame end it presents the total, the beat count and an overflow flag on a valid/ready result port to the downstream consumer.

Parameters:
- WIDTH, 16, data width of the samples, the adder operands and the sum; must match the adder.
- CNT_W, 8, width of the beat counter in a frame.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  sample to accumulate.
- in_valid  input  1  in_data is valid.
- in_last  input  1  marks the final sample of a frame; qualified by in_valid.
- in_ready  output  1  block can accept a sample this cycle.
- add_a  output  WIDTH  adder operand a; always equals acc register.
- add_b  output  WIDTH  adder operand b; always equals in_data.
- add_sum  input  WIDTH  adder result (combinational a + b, modulo 2^WIDTH).
- res_data  output  WIDTH  frame total.
- res_count  output  CNT_W  number of samples accepted in the frame, saturating.
- res_ovf  output  1  sticky: at least one addition in the frame wrapped.
- res_valid  output  1  result fields valid.
- res_ready  input  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, res_valid=0, res_data=0, res_count=0, res_ovf=0. Resulting outputs: in_ready=1, add_a=0.
- Reset asserted mid-frame or while a result is held discards everything. No partial result is emitted.
- Accept: in_valid & in_ready at a rising edge. No combinational path from add_sum to add_a, add_b or in_ready.
- FSM states:
  - IDLE: no frame open. in_ready=1. acc=0, cnt=0, ovf=0.
    - Accept without in_last -> ACC.
    - Accept with in_last -> DONE (single-sample frame).
  - ACC: frame open. in_ready=1.
    - Accept without in_last -> stay in ACC.
    - Accept with in_last -> DONE.
    - No accept -> hold all registers. Gaps in in_valid are allowed.
  - DONE: in_ready=0, res_valid=1, result registers stable.
    - res_valid & res_ready -> IDLE, with acc, cnt and ovf cleared on that edge.
- On every accept:
  - acc <= add_sum.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - ovf <= ovf | (add_sum < acc), unsigned compare = carry out of the adder.
- On an accept with in_last, the same edge loads:
  - res_data <= add_sum.
  - res_count <= saturated cnt+1.
  - res_ovf <= ovf | wrap-of-this-beat.
  - res_valid <= 1.
- Latency: result valid the cycle after the last sample is accepted.
- Throughput: one sample per cycle within a frame. In_ready=0 for every cycle spent in DONE. Earliest first sample of the next frame is accepted the cycle after the result handshake, so minimum one bubble between frames.
- res_* fields hold while res_valid=1 and res_ready=0, for any number of cycles. res_valid deasserts the cycle after the handshake.
- in_last without in_valid is ignored. in_data/in_last are don't-care while in_ready=0.
- Arithmetic: unsigned, modulo 2^WIDTH. The wrapped sum is reported with res_ovf=1; no saturation of the data.

Test Plan:
- Reset then frame 3,5,7 (last on 7), res_ready=1 -> res_valid one cycle after the 7 is accepted. res_data=15, res_count=3, res_ovf=0. In_ready low exactly one cycle.
- Single-sample frame 0x1234 with in_last -> res_data=0x1234, res_count=1, res_ovf=0. FSM goes IDLE->DONE->IDLE.
- Frame 0xFFF0, 0x0020 (last) -> res_data=0x0010, res_ovf=1. Next frame 1,1 (last) -> res_data=2, res_ovf=0 (sticky flag cleared between frames).
- Frame with in_valid gaps (1,_,2,_,_,3 last), then res_ready held low 5 cycles -> res_data=6, res_count=3. Res fields stable and in_ready=0 for all 5 cycles; samples offered during DONE are not consumed.
- 300 samples of value 1 with CNT_W=8 -> res_count=255 (saturated), res_data=300, res_ovf=0.
- rst_n pulsed low asynchronously (mid-cycle) after 2 samples of a frame -> all outputs return to reset values immediately. A following frame 4,4 (last) gives res_data=8, res_count=2.
